uart_time_setter: RTL and testbench

Serial time-setting front end for the clock design. It receives 8N1 UART frames on a single RX line and parses the ASCII command `T`, `H`, `H`, `M`, `M`, CR. A valid command drives a one-cycle load strobe with binary hours/minutes into the time counter's second load port (`timp_ore2` / `timp_minute2` / `load_2`), alongside the manual `setare` path. It is the producing end of the counter's UART load interface.

---
 rtl/ceas_pkg.sv | 46 ++++
 rtl/uart_rx_byte.sv | 105 ++++++++++
 rtl/uart_time_setter.sv | 161 ++++++++++++++++
 tb/tb_uart_time_setter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceas_pkg.sv
// ceas_pkg: shared constants and types for the clock design's UART
// time-setting front end.
//   - ASCII codes recognised by the command parser
//   - hour/minute limits and output widths
//   - parser and byte-receiver state encodings
//   - small helpers for digit checking and tens*10 arithmetic
package ceas_pkg;

  localparam logic [7:0] CHR_T  = 8'h54;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_9  = 8'h39;

  localparam int ORE_MAX = 23;
  localparam int MIN_MAX = 59;
  localparam int ORE_W   = 5;
  localparam int MIN_W   = 6;

  typedef enum logic [2:0] {
    P_IDLE,
    P_H1,
    P_H0,
    P_M1,
    P_M0,
    P_END
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHR_0) && (b <= CHR_9);
  endfunction

  // Multiply-free tens weighting: 8d + 2d, kept in 7 bits (max 99).
  function automatic logic [6:0] times10(input logic [3:0] d);
    logic [6:0] w;
    w = {3'b000, d};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver.
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clock
//   data       out  last received byte (LSB first on the line)
//   byte_valid out  one-cycle strobe in the stop-bit sample cycle, stop bit high
//   frame_err  out  one-cycle strobe in the stop-bit sample cycle, stop bit low
//   busy       out  high from start detect through the stop-bit sample
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronized low
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sample 8 data bits at bit centres
// RX_STOP  | sample stop bit one bit time after the last data bit
module uart_rx_byte
  import ceas_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] START_LD = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       data_q;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic             tc;

  assign rx_s = sync_q[1];
  assign tc   = (cnt_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      sync_q  <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_q <= RX_START;
            cnt_q   <= START_LD;
          end
        end
        RX_START: begin
          if (tc) begin
            if (!rx_s) begin
              state_q <= RX_DATA;
              cnt_q   <= BIT_LD;
              bit_q   <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (tc) begin
            data_q <= {rx_s, data_q[7:1]};
            cnt_q  <= BIT_LD;
            if (bit_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          // Straight back to idle so a start bit right after the stop bit is caught.
          if (tc) begin
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign byte_valid = (state_q == RX_STOP) && tc && rx_s;
  assign frame_err  = (state_q == RX_STOP) && tc && !rx_s;
  assign busy       = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_time_setter.sv
// uart_time_setter: parses "T HH MM CR" commands from a UART line and
// produces a one-cycle load strobe with binary hours/minutes for the time
// counter's second load port.
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   rx         in   UART receive line, idle high
//   ore        out  loaded hours 0..23
//   minute     out  loaded minutes 0..59
//   load_timp  out  one-cycle load strobe, ore/minute valid with it
//   cmd_err    out  one-cycle strobe on rejected command or framing error
//   rx_busy    out  frame reception in progress
//
// state  | meaning
// P_IDLE | waiting for 'T', other bytes ignored
// P_H1   | expecting hours tens digit
// P_H0   | expecting hours units digit
// P_M1   | expecting minutes tens digit
// P_M0   | expecting minutes units digit
// P_END  | expecting CR, then range check
module uart_time_setter
  import ceas_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [ORE_W-1:0] ore,
  output logic [MIN_W-1:0] minute,
  output logic             load_timp,
  output logic             cmd_err,
  output logic             rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [7:0] rx_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (rx_busy)
  );

  parse_state_e     pstate_q;
  logic [3:0]       h1_q, h0_q, m1_q, m0_q;
  logic [ORE_W-1:0] ore_q;
  logic [MIN_W-1:0] minute_q;
  logic             load_q;
  logic             err_q;

  logic [6:0] hours_d;
  logic [6:0] mins_d;
  logic       range_ok;
  logic [3:0] dig;
  logic       dig_ok;

  always_comb begin
    hours_d  = times10(h1_q) + {3'b000, h0_q};
    mins_d   = times10(m1_q) + {3'b000, m0_q};
    range_ok = (hours_d <= 7'(ORE_MAX)) && (mins_d <= 7'(MIN_MAX));
    dig      = rx_data[3:0];
    dig_ok   = is_digit(rx_data);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pstate_q <= P_IDLE;
      h1_q     <= '0;
      h0_q     <= '0;
      m1_q     <= '0;
      m0_q     <= '0;
      ore_q    <= '0;
      minute_q <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      err_q  <= 1'b0;
      if (frame_err) begin
        pstate_q <= P_IDLE;
        err_q    <= 1'b1;
      end else if (byte_valid) begin
        // 'T' restarts a command from any state and is never an error.
        if (rx_data == CHR_T) begin
          pstate_q <= P_H1;
          h1_q     <= '0;
          h0_q     <= '0;
          m1_q     <= '0;
          m0_q     <= '0;
        end else begin
          case (pstate_q)
            P_IDLE: ;
            P_H1: begin
              if (dig_ok) begin
                h1_q     <= dig;
                pstate_q <= P_H0;
              end else begin
                err_q    <= 1'b1;
                pstate_q <= P_IDLE;
              end
            end
            P_H0: begin
              if (dig_ok) begin
                h0_q     <= dig;
                pstate_q <= P_M1;
              end else begin
                err_q    <= 1'b1;
                pstate_q <= P_IDLE;
              end
            end
            P_M1: begin
              if (dig_ok) begin
                m1_q     <= dig;
                pstate_q <= P_M0;
              end else begin
                err_q    <= 1'b1;
                pstate_q <= P_IDLE;
              end
            end
            P_M0: begin
              if (dig_ok) begin
                m0_q     <= dig;
                pstate_q <= P_END;
              end else begin
                err_q    <= 1'b1;
                pstate_q <= P_IDLE;
              end
            end
            P_END: begin
              if ((rx_data == CHR_CR) && range_ok) begin
                ore_q    <= hours_d[ORE_W-1:0];
                minute_q <= mins_d[MIN_W-1:0];
                load_q   <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              pstate_q <= P_IDLE;
            end
            default: pstate_q <= P_IDLE;
          endcase
        end
      end
    end
  end

  assign ore       = ore_q;
  assign minute    = minute_q;
  assign load_timp = load_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_time_setter.sv
module tb_uart_time_setter;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int EV_NONE  = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int kind;
    int h;
    int m;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load_timp;
  logic       cmd_err;
  logic       rx_busy;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_load = 0;
  int  n_err = 0;
  int  last_len = 0;
  int  exp_ore = 0;
  int  exp_min = 0;
  bit  tail_mode = 1'b0;
  ev_t exp_q[$];
  int  got_h[$];
  int  got_m[$];
  int  m_len = 0;
  int  m_d[4];

  uart_time_setter #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .ore      (ore),
    .minute   (minute),
    .load_timp(load_timp),
    .cmd_err  (cmd_err),
    .rx_busy  (rx_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Command model: text since the last 'T', evaluated when CR arrives.
  task automatic model_byte(input logic [7:0] b, input bit bad_stop);
    int k = EV_NONE;
    int h = 0;
    int m = 0;
    if (bad_stop) begin
      k = EV_ERR;
      m_len = 0;
    end else if (b == 8'h54) begin
      m_len = 1;
    end else if (m_len == 0) begin
      k = EV_NONE;
    end else if (m_len <= 4) begin
      if (b >= 8'h30 && b <= 8'h39) begin
        m_d[m_len-1] = int'(b) - 48;
        m_len++;
      end else begin
        k = EV_ERR;
        m_len = 0;
      end
    end else begin
      h = 10 * m_d[0] + m_d[1];
      m = 10 * m_d[2] + m_d[3];
      if (b == 8'h0D && h < 24 && m < 60) k = EV_LOAD;
      else k = EV_ERR;
      m_len = 0;
    end
    exp_q.push_back('{k, h, m});
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit modeled);
    if (modeled) model_byte(b, bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s, input bit modeled);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b0, modeled);
  endtask

  task automatic send_cmd(input string s);
    send_str(s, 1'b1);
    send_frame(8'h0D, 1'b0, 1'b1);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clock);
  endtask

  // Per-cycle compare against the model; an expected event falls due in the
  // cycle right after the frame's stop-bit sample, i.e. when rx_busy drops.
  initial begin
    ev_t ev;
    int  run = 0;
    bit  busy_prev = 1'b0;
    int  e_load;
    int  e_err;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_ore = 0;
        exp_min = 0;
        exp_q.delete();
        busy_prev = 1'b0;
        run = 0;
        chk("rst_ore", ore, 0);
        chk("rst_minute", minute, 0);
        chk("rst_load", load_timp, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_busy", rx_busy, 0);
      end else begin
        e_load = 0;
        e_err  = 0;
        if (rx_busy) run++;
        if (busy_prev && !rx_busy) begin
          last_len = run;
          if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            if (run < 9 * CPB || run > 10 * CPB)
              chk("busy_span_in_range", run, 19 * CPB / 2);
            if (ev.kind == EV_LOAD) begin
              e_load  = 1;
              exp_ore = ev.h;
              exp_min = ev.m;
            end
            if (ev.kind == EV_ERR) e_err = 1;
          end
          run = 0;
        end
        chk("load_timp", load_timp, e_load);
        if (!tail_mode) chk("cmd_err", cmd_err, e_err);
        chk("ore", ore, exp_ore);
        chk("minute", minute, exp_min);
        if (load_timp) begin
          n_load++;
          got_h.push_back(int'(ore));
          got_m.push_back(int'(minute));
        end
        if (cmd_err) n_err++;
        busy_prev = rx_busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d, expected %0d", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int err_base;
    #22 reset = 1'b1;
    idle(3);

    send_cmd("T1234");
    idle(2);
    chk("n_load_a", n_load, 1);
    chk("load0_h", at(got_h, 0), 12);
    chk("load0_m", at(got_m, 0), 34);
    chk("ore_a", ore, 12);
    chk("minute_a", minute, 34);

    send_cmd("T2359");
    send_cmd("T0000");
    idle(2);
    chk("n_load_b", n_load, 3);
    chk("load1_h", at(got_h, 1), 23);
    chk("load1_m", at(got_m, 1), 59);
    chk("load2_h", at(got_h, 2), 0);
    chk("load2_m", at(got_m, 2), 0);

    send_cmd("T12T0945");
    idle(2);
    chk("n_load_c", n_load, 4);
    chk("n_err_c", n_err, 0);
    chk("load3_h", at(got_h, 3), 9);
    chk("load3_m", at(got_m, 3), 45);

    send_cmd("T2400");
    idle(2);
    chk("n_err_h24", n_err, 1);
    chk("n_load_h24", n_load, 4);
    chk("ore_keep_h24", ore, 9);
    chk("minute_keep_h24", minute, 45);

    send_cmd("T1260");
    idle(2);
    chk("n_err_m60", n_err, 2);
    chk("ore_keep_m60", ore, 9);
    chk("minute_keep_m60", minute, 45);

    send_str("T1a", 1'b1);
    idle(2);
    chk("n_err_alpha", n_err, 3);

    send_frame(8'h54, 1'b1, 1'b1);
    idle(3);
    chk("n_err_frame", n_err, 4);
    send_frame(8'h0D, 1'b0, 1'b1);
    idle(2);
    chk("n_err_discard", n_err, 4);

    last_len = 0;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    idle(3);
    chk("glitch_busy_seen", (last_len >= 1) ? 1 : 0, 1);
    chk("glitch_busy_short", (last_len <= CPB / 2 + 1) ? 1 : 0, 1);
    chk("n_load_glitch", n_load, 4);
    chk("n_err_glitch", n_err, 4);

    send_str("T123", 1'b1);
    tail_mode = 1'b1;
    fork
      send_frame(8'h34, 1'b0, 1'b0);
      begin
        repeat (35) @(negedge clock);
        #2 reset = 1'b0;
        m_len = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("mid_rst_ore", ore, 0);
        chk("mid_rst_minute", minute, 0);
        chk("mid_rst_busy", rx_busy, 0);
        reset = 1'b1;
      end
    join
    send_frame(8'h0D, 1'b0, 1'b0);
    idle(12);
    chk("tail_busy_idle", rx_busy, 0);
    chk("tail_no_load", n_load, 4);
    tail_mode = 1'b0;
    err_base = n_err;

    send_cmd("T0107");
    idle(3);
    chk("n_load_post", n_load, 5);
    chk("n_err_post", n_err, err_base);
    chk("load4_h", at(got_h, 4), 1);
    chk("load4_m", at(got_m, 4), 7);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
